f1_lights_out_timer: RTL and testbench

Counterpart to the F1 start-lights sequencer. It consumes the sequencer's `cmd_seq`/`cmd_delay` command pair. When the last light turns on (`cmd_delay` rises), it waits a pseudo-random number of ticks and then pulses `time_out` to signal lights-out. It then measures the driver's reaction time in ticks up to the `trigger` press, and flags false starts (a press before lights-out). It shares the `en` tick from the clock-divider with the sequencer.

---
 rtl/f1_pkg.sv | 16 +
 rtl/f1_lfsr.sv | 30 +++
 rtl/f1_lights_out_timer.sv | 131 +++++++++++++
 tb/tb_f1_lights_out_timer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-lights sequencer and lights-out timer.
package f1_pkg;

  // Lights-out timer control states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DELAY      = 2'd1,
    LIGHTS_OUT = 2'd2,
    REACT      = 2'd3
  } f1_state_e;

  // Feedback taps for x^7 + x^3 + 1 (bits 6 and 2 of a left-shifting register)
  localparam int unsigned               LFSR_TAP_W = 7;
  localparam logic [LFSR_TAP_W-1:0]     LFSR_TAPS  = 7'b100_0100;

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR used as the lights-out random source.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int unsigned        LFSR_W = 7,
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(7'h01)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & TAPS);
  assign q    = r_q;

  // Shift every clock; a non-zero seed keeps the sequence away from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/f1_lights_out_timer.sv
// Random lights-out delay after the last light, then driver reaction timing.
module f1_lights_out_timer
  import f1_pkg::*;
#(
  parameter int unsigned        LFSR_W    = 7,
  parameter logic [LFSR_W-1:0]  SEED      = LFSR_W'(7'h01),
  parameter int unsigned        MIN_DELAY = 4,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_seq,
  input  logic             cmd_delay,
  input  logic             trigger,
  output logic             time_out,
  output logic             react_valid,
  output logic [CNT_W-1:0] react_time,
  output logic             false_start,
  output logic             busy
);

  localparam int unsigned DLY_W = LFSR_W + 1;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_start;

  logic              r_cmd_delay_q;
  f1_state_e         r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_time_out;
  logic              r_react_valid;
  logic [CNT_W-1:0]  r_react_time;
  logic              r_false_start;
  logic              r_busy;

  f1_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Rising edge of cmd_delay, ignored when cmd_seq is also high
  assign w_start = cmd_delay && !r_cmd_delay_q && !cmd_seq;

  // Edge-detect history; resets high so a level already present is not a start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_delay_q <= 1'b1;
    end else begin
      r_cmd_delay_q <= cmd_delay;
    end
  end

  // Control FSM with delay and reaction counters; outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dly_cnt     <= '0;
      r_cnt         <= '0;
      r_time_out    <= 1'b0;
      r_react_valid <= 1'b0;
      r_react_time  <= '0;
      r_false_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_time_out    <= 1'b0;
      r_react_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dly_cnt     <= DLY_W'(w_lfsr) + DLY_W'(MIN_DELAY);
            r_false_start <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= DELAY;
          end
        end
        DELAY: begin
          // A press beats the final decrement
          if (trigger) begin
            r_false_start <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else if (en) begin
            r_dly_cnt <= r_dly_cnt - DLY_W'(1);
            if (r_dly_cnt == DLY_W'(1)) begin
              r_time_out <= 1'b1;
              r_state    <= LIGHTS_OUT;
            end
          end
        end
        LIGHTS_OUT: begin
          r_cnt <= '0;
          if (trigger) begin
            r_react_time  <= '0;
            r_react_valid <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_state <= REACT;
          end
        end
        REACT: begin
          // Report the count before any same-cycle increment
          if (trigger) begin
            r_react_time  <= r_cnt;
            r_react_valid <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else if (en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign time_out    = r_time_out;
  assign react_valid = r_react_valid;
  assign react_time  = r_react_time;
  assign false_start = r_false_start;
  assign busy        = r_busy;

endmodule

// File: tb/tb_f1_lights_out_timer.sv
// Scoreboard bench for f1_lights_out_timer: two instances (16-bit and 4-bit
// reaction counters) driven in parallel and compared against a tick-level model.
module tb_f1_lights_out_timer;

  localparam int MIN_DLY = 4;
  localparam int SAT_A   = 65535;
  localparam int SAT_B   = 15;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic en        = 1'b1;
  logic cmd_seq   = 1'b0;
  logic cmd_delay = 1'b0;
  logic trigger   = 1'b0;

  logic        to_a, rv_a, fs_a, busy_a;
  logic [15:0] rt_a;
  logic        to_b, rv_b, fs_b, busy_b;
  logic [3:0]  rt_b;

  f1_lights_out_timer #(.CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .trigger(trigger), .time_out(to_a), .react_valid(rv_a), .react_time(rt_a),
    .false_start(fs_a), .busy(busy_a)
  );

  f1_lights_out_timer #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .trigger(trigger), .time_out(to_b), .react_valid(rv_b), .react_time(rt_b),
    .false_start(fs_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Expected output events: kind 0 = time_out, kind 1 = react_valid
  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;
  int  en_pct   = 100;

  // Reference model state
  logic [6:0] m_lfsr  = 7'h01;
  bit         m_prev  = 1'b1;
  int         m_wait  = 0;   // ticks still to elapse before lights-out, 0 = not waiting
  bit         m_lo    = 1'b0;
  int         m_react = -1;  // ticks counted since lights-out, -1 = not timing
  bit         m_fs    = 1'b0;
  int         m_rt    = 0;
  bit         m_busy  = 1'b0;

  function automatic longint sat(input int v, input int m);
    return (v > m) ? longint'(m) : longint'(v);
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.val  = val;
    q.push_back(e);
  endfunction

  // Behavioural model, evaluated once per rising edge on the sampled inputs
  initial begin
    bit start;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_lfsr = 7'h01; m_prev = 1'b1; m_wait = 0; m_lo = 1'b0;
        m_react = -1; m_fs = 1'b0; m_rt = 0;
      end else begin
        start = cmd_delay && !m_prev && !cmd_seq;
        if (m_lo) begin
          m_lo = 1'b0;
          if (trigger) begin m_rt = 0; push_ev(1, 0); end
          else m_react = 0;
        end else if (m_react >= 0) begin
          if (trigger) begin m_rt = m_react; push_ev(1, m_react); m_react = -1; end
          else if (en) m_react++;
        end else if (m_wait > 0) begin
          if (trigger) begin m_fs = 1'b1; m_wait = 0; end
          else if (en) begin
            m_wait--;
            if (m_wait == 0) begin m_lo = 1'b1; push_ev(0, 0); end
          end
        end else if (start) begin
          m_wait = int'(m_lfsr) + MIN_DLY;
          m_fs   = 1'b0;
        end
        m_prev = cmd_delay;
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
      end
      m_busy = m_lo || (m_react >= 0) || (m_wait > 0);
    end
  end

  // Monitor: compares both instances every cycle and retires expected events
  initial begin
    bit has, exp_to, exp_rv;
    forever begin
      @(negedge clk);
      cmp("a.busy", busy_a, m_busy);
      cmp("b.busy", busy_b, m_busy);
      cmp("a.false_start", fs_a, m_fs);
      cmp("b.false_start", fs_b, m_fs);
      cmp("a.react_time_hold", rt_a, sat(m_rt, SAT_A));
      cmp("b.react_time_hold", rt_b, sat(m_rt, SAT_B));
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event kind=%0d got=none expected_cyc=%0d", q[0].kind, q[0].cyc);
        void'(q.pop_front());
      end
      has    = (q.size() > 0) && (q[0].cyc == cyc);
      exp_to = has && (q[0].kind == 0);
      exp_rv = has && (q[0].kind == 1);
      cmp("a.time_out", to_a, exp_to);
      cmp("b.time_out", to_b, exp_to);
      cmp("a.react_valid", rv_a, exp_rv);
      cmp("b.react_valid", rv_b, exp_rv);
      if (exp_rv) begin
        cmp("a.react_time", rt_a, sat(q[0].val, SAT_A));
        cmp("b.react_time", rt_b, sat(q[0].val, SAT_B));
      end
      if (has) void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    en = ($urandom_range(0, 99) < en_pct);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_seq(input bit err);
    cmd_delay = 1'b0; cmd_seq = 1'b0;
    tick();
    cmd_delay = 1'b1; cmd_seq = err;
    tick();
    cmd_seq = 1'b0;
  endtask

  task automatic wait_to(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (to_a) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_time_out got=no_pulse expected=pulse within 4000 cycles");
      rst = 1'b1; tick(); rst = 1'b0;
    end
  endtask

  // Full run: start, lights-out, press r cycles after the lights-out cycle
  task automatic normal_run(input int r);
    bit ok;
    start_seq(1'b0);
    wait_to(ok);
    if (ok) begin
      ticks(r);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
    end
    cmd_delay = 1'b0;
  endtask

  task automatic false_run(input int k);
    start_seq(1'b0);
    ticks(k - 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    ticks(10);
    cmd_delay = 1'b0;
  endtask

  initial begin
    int kind;
    // Reset with cmd_delay already high
    rst = 1'b1; cmd_delay = 1'b1; en = 1'b1;
    ticks(3);
    cmp("reset.time_out", to_a, 0);
    cmp("reset.react_valid", rv_a, 0);
    cmp("reset.react_time", rt_a, 0);
    cmp("reset.false_start", fs_a, 0);
    cmp("reset.busy", busy_a, 0);
    rst = 1'b0;
    ticks(50);
    cmp("held_delay.busy", busy_a, 0);

    // Lights-out then a press 12 ticks into the reaction window
    en_pct = 100;
    normal_run(13);
    cmp("react12.react_time", rt_a, 12);
    cmp("react12.busy", busy_a, 0);
    ticks(3);

    // False start two cycles after start, then the next start clears it
    false_run(2);
    cmp("false_start.flag", fs_a, 1);
    start_seq(1'b0);
    cmp("false_start.cleared", fs_a, 0);
    ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    cmd_delay = 1'b0;
    ticks(2);

    // Press during the lights-out cycle
    normal_run(0);
    cmp("lights_out_press.react_time", rt_a, 0);
    ticks(3);

    // Reaction of 20 ticks saturates the 4-bit instance
    normal_run(21);
    cmp("sat.a.react_time", rt_a, 20);
    cmp("sat.b.react_time", rt_b, 15);
    ticks(3);

    // Reset in the middle of the delay
    start_seq(1'b0);
    ticks(3);
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("mid_rst.busy", busy_a, 0);
    cmp("mid_rst.time_out", to_a, 0);
    ticks(150);
    cmd_delay = 1'b0;

    // cmd_seq and cmd_delay rising together
    start_seq(1'b1);
    ticks(20);
    cmp("proto_err.busy", busy_a, 0);
    cmd_delay = 1'b0;
    tick();

    // Randomised sessions
    for (int n = 0; n < 40; n++) begin
      en_pct = $urandom_range(30, 100);
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        normal_run($urandom_range(0, 40));
      end else if (kind < 8) begin
        false_run($urandom_range(1, 4));
      end else if (kind == 8) begin
        start_seq(1'b1);
        ticks(15);
        cmd_delay = 1'b0;
      end else begin
        start_seq(1'b0);
        ticks($urandom_range(1, 6));
        rst = 1'b1; tick(); rst = 1'b0;
        ticks(10);
        cmd_delay = 1'b0;
      end
      // Idle gap; presses here must be ignored
      for (int g = 0; g < 4; g++) begin
        trigger = ($urandom_range(0, 3) == 0);
        tick();
      end
      trigger = 1'b0;
      tick();
    end

    ticks(3);
    cmp("scoreboard.leftover", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
